sar_result_reader: RTL and testbench
====================================

Name: sar_result_reader

Overview:
Reader end of the SAR conversion-result interface. It captures each completed conversion word on the rising edge of conv_done and buffers it in a small FIFO. It then transmits the buffered words off-chip as serial frames on a cs_n/sclk/sdo link, MSB first. It sits beside sarlogic in the top-level wrapper and drives three uio_out pins plus status.

Parameters:
DATA_W, 12, width of one conversion word
FIFO_DEPTH, 4, number of buffered words (power of two, >=2)
CLK_DIV, 2, clk cycles per sclk half-period (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset (top level drives ~rst_n)
sample_code  input  DATA_W  conversion result from sarlogic bitout; valid when conv_done rises
conv_done  input  1  conversion-complete level from sarlogic; may stay high for several cycles
clr_ovf  input  1  single-cycle pulse that clears the overflow flag
cs_n  output  1  frame select, active low
sclk  output  1  serial clock, idles low; data is sampled by the receiver on the rising edge
sdo  output  1  serial data, MSB first
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered
overflow  output  1  sticky flag: a sample was dropped
frame_done  output  1  one-cycle pulse when a frame ends

Behaviour:
- Reset (synchronous, active-high): cs_n=1, sclk=0, sdo=0, fifo_count=0, overflow=0, frame_done=0. The FIFO is emptied and the FSM goes to IDLE. Reset asserted mid-frame aborts the frame; cs_n goes high on the next edge and the partial word is lost.
- Capture:
  - conv_done is registered once (conv_d) and edge-detected as conv_done & ~conv_d.
  - On a rising edge, sample_code is pushed into the FIFO on that same clock edge.
  - A level held high produces exactly one push.
- FIFO full on a push: the word is dropped and overflow is set.
  - Exception: if a pop occurs in the same cycle, the push succeeds and count stays at FIFO_DEPTH.
- Simultaneous push and pop on an empty FIFO is not possible, because the pop requires count>0 in the prior cycle.
- Overflow flag: clr_ovf clears it. If clr_ovf coincides with a new drop, set wins.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: cs_n=1, sclk=0. If fifo_count>0, pop the head into the shift register and go to SHIFT. bit_idx=DATA_W-1, div counter=0.
  - SHIFT: cs_n=0. Each bit lasts 2*CLK_DIV cycles: CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1. sdo changes only at the start of the sclk=0 phase.
  - SHIFT exit: after the last bit's high phase, go to GAP with sclk=0.
  - GAP: cs_n=1 for exactly 2 cycles. frame_done pulses in the first GAP cycle. Then return to IDLE.
- Frame timing:
  - cs_n low for DATA_W*2*CLK_DIV cycles (48 at defaults).
  - Minimum frame-to-frame spacing = 1 (IDLE) + 48 + 2 = 51 cycles.
- All outputs are registered; no combinational path from inputs to cs_n, sclk or sdo.
- Counters wrap only at their defined terminal counts. FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package sar_pkg holds:
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2)
  - GAP_CYCLES=2
  - default DATA_W=12, shared with sarlogic
- One natural sub-module: sar_sync_fifo, a parameterised synchronous FIFO.
  - Inputs/outputs: push, pop, din, dout, count, full, empty.
  - Same-cycle push/pop allowed when full.
- Edge detect, overflow logic, FSM and shifter live in the top module.

Test Plan:
- Reset, then one conv_done pulse with sample_code=12'hA5C -> one frame:
  - cs_n low for 48 cycles, 12 sclk rising edges
  - sampled bits 1010_0101_1100
  - frame_done pulses once
  - fifo_count returns to 0
- conv_done held high 10 cycles with code 12'h123 -> exactly one push and one frame transmitting 12'h123.
- Six conv_done edges 3 cycles apart (codes 1..6) while the first frame is in flight:
  - first pop at count 1
  - words 2..5 buffered, count peaks at 4
  - word 6 dropped, overflow=1
  - frames carry 1,2,3,4,5 in order
- clr_ovf pulse after overflow -> overflow=0. Repeat with clr_ovf coinciding with a drop -> overflow stays 1.
- FIFO full and an IDLE pop coincides with a conv_done edge -> the push is accepted, count stays 4, no overflow.
- Reset asserted at cycle 20 of a frame -> next edge gives cs_n=1, sclk=0, fifo_count=0. No frame_done pulse. The next conv_done produces a clean full frame.

Source files
------------

// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Definitions shared by the SAR result reader and its neighbours:
//   - sar_state_e : serial-frame FSM encoding (IDLE, SHIFT, GAP)
//   - GAP_CYCLES  : cycles cs_n stays high after each frame
//   - SAR_DATA_W  : default conversion word width, also used by sarlogic
// ---------------------------------------------------------------------------
package sar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } sar_state_e;

   localparam int GAP_CYCLES = 2;
   localparam int SAR_DATA_W = 12;

endpackage

// File: rtl/sar_sync_fifo.sv
// ---------------------------------------------------------------------------
// sar_sync_fifo
// Single-clock FIFO holding conversion words until the serialiser takes them.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push, din  : write request and data
//   pop, dout  : read request and head-of-queue data (valid while !empty)
//   count      : words currently stored
//   full/empty : status flags derived from count
// ---------------------------------------------------------------------------
module sar_sync_fifo
   import sar_pkg::*;
#(
   parameter int DATA_W = SAR_DATA_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic              w_wr;
   logic              w_rd;

   // When full, the same-cycle pop frees the slot the write lands in.
   assign w_wr  = push & (~full | pop);
   assign w_rd  = pop & ~empty;

   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign dout  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= din;
   end

endmodule

// File: rtl/sar_result_reader.sv
// ---------------------------------------------------------------------------
// sar_result_reader
// Captures each conversion word on the rising edge of conv_done, buffers it
// in a small FIFO and sends buffered words off-chip as MSB-first serial
// frames on cs_n/sclk/sdo.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   sample_code  : conversion result, valid when conv_done rises
//   conv_done    : conversion-complete level (may stay high several cycles)
//   clr_ovf      : one-cycle pulse clearing the overflow flag
//   cs_n         : frame select, active low
//   sclk         : serial clock, idles low, receiver samples on rising edge
//   sdo          : serial data, MSB first
//   fifo_count   : words currently buffered
//   overflow     : sticky, a word was dropped because the FIFO was full
//   frame_done   : one-cycle pulse in the first cycle after a frame
// ---------------------------------------------------------------------------
module sar_result_reader
   import sar_pkg::*;
#(
   parameter int DATA_W     = SAR_DATA_W,
   parameter int FIFO_DEPTH = 4,
   parameter int CLK_DIV    = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             sample_code,
   input  logic                          conv_done,
   input  logic                          clr_ovf,
   output logic                          cs_n,
   output logic                          sclk,
   output logic                          sdo,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          frame_done
);

   localparam int BIT_LEN = 2 * CLK_DIV;
   localparam int CNT_W   = $clog2((BIT_LEN > GAP_CYCLES) ? BIT_LEN : GAP_CYCLES);
   localparam int BIT_W   = $clog2(DATA_W);

   sar_state_e          r_state, w_state_nx;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
   logic [BIT_W-1:0]    r_bit, w_bit_nx;
   logic [DATA_W-1:0]   r_shreg;
   logic                r_conv_d;
   logic                r_cs_n, r_sclk, r_sdo, r_fd, r_ovf;
   logic                w_cs_n_nx, w_sclk_nx, w_sdo_nx, w_fd_nx;
   logic                w_push, w_pop, w_drop;
   logic [DATA_W-1:0]   w_fifo_dout;
   logic                w_fifo_full, w_fifo_empty;

   // Capture stage: one push per conv_done rising edge.
   assign w_push = conv_done & ~r_conv_d;
   assign w_drop = w_push & w_fifo_full & ~w_pop;

   sar_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (sample_code),
      .dout  (w_fifo_dout),
      .count (fifo_count),
      .full  (w_fifo_full),
      .empty (w_fifo_empty)
   );

   // Serialiser stage: next-state and next-output decode. Outputs are
   // computed one cycle ahead so every pin comes straight from a flop.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_bit_nx   = r_bit;
      w_pop      = 1'b0;
      w_cs_n_nx  = 1'b1;
      w_sclk_nx  = 1'b0;
      w_sdo_nx   = 1'b0;
      w_fd_nx    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop      = 1'b1;
               w_state_nx = ST_SHIFT;
               w_cnt_nx   = '0;
               w_bit_nx   = BIT_W'(DATA_W - 1);
               w_cs_n_nx  = 1'b0;
               w_sdo_nx   = w_fifo_dout[DATA_W-1];
            end
         end
         ST_SHIFT: begin
            w_cs_n_nx = 1'b0;
            w_sdo_nx  = r_sdo;
            if (r_cnt == CNT_W'(BIT_LEN - 1)) begin
               // End of a bit's high phase: next bit, or close the frame.
               w_cnt_nx = '0;
               if (r_bit == '0) begin
                  w_state_nx = ST_GAP;
                  w_cs_n_nx  = 1'b1;
                  w_sdo_nx   = 1'b0;
                  w_fd_nx    = 1'b1;
               end else begin
                  w_bit_nx = r_bit - 1'b1;
                  w_sdo_nx = r_shreg[r_bit - 1'b1];
               end
            end else begin
               w_cnt_nx  = r_cnt + 1'b1;
               w_sclk_nx = ((r_cnt + 1'b1) >= CNT_W'(CLK_DIV));
            end
         end
         ST_GAP: begin
            if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
               w_state_nx = ST_IDLE;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // Register stage: control state and registered pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_conv_d <= 1'b0;
         r_cs_n   <= 1'b1;
         r_sclk   <= 1'b0;
         r_sdo    <= 1'b0;
         r_fd     <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_cnt    <= w_cnt_nx;
         r_bit    <= w_bit_nx;
         r_conv_d <= conv_done;
         r_cs_n   <= w_cs_n_nx;
         r_sclk   <= w_sclk_nx;
         r_sdo    <= w_sdo_nx;
         r_fd     <= w_fd_nx;
         // A new drop outranks a simultaneous clear.
         r_ovf    <= w_drop | (r_ovf & ~clr_ovf);
      end
   end

   always_ff @(posedge clk) begin
      if (w_pop) r_shreg <= w_fifo_dout;
   end

   assign cs_n       = r_cs_n;
   assign sclk       = r_sclk;
   assign sdo        = r_sdo;
   assign overflow   = r_ovf;
   assign frame_done = r_fd;

endmodule

// File: tb/tb_sar_result_reader.sv
module tb_sar_result_reader;

   localparam int DATA_W     = 12;
   localparam int FIFO_DEPTH = 4;
   localparam int CLK_DIV    = 2;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;
   localparam int LOW_LEN    = DATA_W * 2 * CLK_DIV;
   localparam int FRAME_LEN  = LOW_LEN + 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              conv_done = 1'b0;
   logic              clr_ovf = 1'b0;
   logic [DATA_W-1:0] sample_code = '0;
   logic              cs_n, sclk, sdo, overflow, frame_done;
   logic [CW-1:0]     fifo_count;

   int checks = 0;
   int failures = 0;

   sar_result_reader #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CLK_DIV    (CLK_DIV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_code (sample_code),
      .conv_done   (conv_done),
      .clr_ovf     (clr_ovf),
      .cs_n        (cs_n),
      .sclk        (sclk),
      .sdo         (sdo),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of words plus the position inside the
   // current frame timeline (-1 = link idle, 0..LOW_LEN-1 = bits on the
   // wire, LOW_LEN..LOW_LEN+1 = gap).
   logic [DATA_W-1:0] m_q[$];
   logic [DATA_W-1:0] m_sent[$];
   logic [DATA_W-1:0] m_word = '0;
   int                m_phase = -1;
   bit                m_ovf = 1'b0;
   bit                m_conv_d = 1'b0;
   bit                m_pop, m_push, m_drop;

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_sent.delete();
         m_phase  = -1;
         m_ovf    = 1'b0;
         m_conv_d = 1'b0;
      end else begin
         m_pop  = (m_phase < 0) && (m_q.size() > 0);
         m_push = conv_done && !m_conv_d;
         m_drop = m_push && (m_q.size() == FIFO_DEPTH) && !m_pop;
         if (m_pop) begin
            m_word  = m_q.pop_front();
            m_sent.push_back(m_word);
            m_phase = 0;
         end else if (m_phase >= 0) begin
            m_phase++;
            if (m_phase == FRAME_LEN) m_phase = -1;
         end
         if (m_push && !m_drop) m_q.push_back(sample_code);
         if (m_drop) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         m_conv_d = conv_done;
      end
   end

   // Compare process: pins against the model every cycle, plus a receiver
   // that reassembles frames from cs_n/sclk/sdo.
   bit                chk_en = 1'b0;
   bit                e_in;
   logic              e_sdo;
   int                n_frames = 0;
   logic [DATA_W-1:0] dec_log[$];
   logic [DATA_W-1:0] dec_word = '0;
   logic [DATA_W-1:0] exp_word;
   int                low_cnt = 0, rises = 0, last_low = 0, last_rises = 0;
   logic              prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         e_in  = (m_phase >= 0) && (m_phase < LOW_LEN);
         e_sdo = e_in ? m_word[DATA_W-1 - m_phase/(2*CLK_DIV)] : 1'b0;
         chk("cs_n", 32'(cs_n), 32'(!e_in));
         chk("sclk", 32'(sclk), 32'(e_in && ((m_phase % (2*CLK_DIV)) >= CLK_DIV)));
         chk("sdo", 32'(sdo), 32'(e_sdo));
         chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("frame_done", 32'(frame_done), 32'(m_phase == LOW_LEN));
         if (!cs_n) begin
            low_cnt++;
            if (sclk && !prev_sclk) begin
               dec_word = {dec_word[DATA_W-2:0], sdo};
               rises++;
            end
         end
         if (frame_done) begin
            n_frames++;
            dec_log.push_back(dec_word);
            last_low   = low_cnt;
            last_rises = rises;
            chk("sent_queue_nonempty", 32'(m_sent.size() > 0), 32'd1);
            if (m_sent.size() > 0) begin
               exp_word = m_sent.pop_front();
               chk("frame_word", 32'(dec_word), 32'(exp_word));
            end
            chk("frame_low_cycles", 32'(low_cnt), 32'(LOW_LEN));
            chk("frame_sclk_rises", 32'(rises), 32'(DATA_W));
            low_cnt = 0; rises = 0; dec_word = '0;
         end else if (cs_n) begin
            low_cnt = 0; rises = 0; dec_word = '0;
         end
         prev_sclk = sclk;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_frames(input int target, input int max_cyc);
      int n = 0;
      while (n_frames < target && n < max_cyc) begin
         tick();
         n++;
      end
      chk("wait_frames_in_time", 32'(n_frames >= target), 32'd1);
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (!(m_phase < 0 && m_q.size() == 0) && n < max_cyc) begin
         tick();
         n++;
      end
      chk("wait_idle_in_time", 32'(m_phase < 0 && m_q.size() == 0), 32'd1);
      repeat (3) tick();
   endtask

   task automatic edge3(input logic [DATA_W-1:0] code, input bit clr);
      sample_code = code;
      conv_done   = 1'b1;
      clr_ovf     = clr;
      tick();
      conv_done   = 1'b0;
      clr_ovf     = 1'b0;
      tick();
      tick();
   endtask

   int peak;
   int nf;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      chk_en = 1'b1;
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_sdo", 32'(sdo), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // Single word 12'hA5C
      sample_code = 12'hA5C;
      conv_done   = 1'b1;
      tick();
      conv_done   = 1'b0;
      wait_frames(1, 200);
      chk("a5c_word", 32'(dec_log[0]), 32'h0A5C);
      chk("a5c_low_cycles", 32'(last_low), 32'd48);
      chk("a5c_sclk_rises", 32'(last_rises), 32'd12);
      wait_idle(200);
      chk("a5c_frames", 32'(n_frames), 32'd1);
      chk("a5c_count_empty", 32'(fifo_count), 32'd0);

      // conv_done held high for 10 cycles
      sample_code = 12'h123;
      conv_done   = 1'b1;
      repeat (10) tick();
      conv_done   = 1'b0;
      wait_frames(2, 300);
      wait_idle(300);
      chk("held_frames", 32'(n_frames), 32'd2);
      chk("held_word", 32'(dec_log[1]), 32'h0123);

      // Six edges 3 cycles apart while the first frame is in flight
      peak = 0;
      for (int i = 1; i <= 6; i++) begin
         edge3(DATA_W'(i), 1'b0);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      chk("burst_overflow_set", 32'(overflow), 32'd1);
      wait_frames(7, 600);
      wait_idle(300);
      chk("burst_peak_count", 32'(peak), 32'd4);
      chk("burst_frames", 32'(n_frames), 32'd7);
      for (int k = 0; k < 5; k++)
         chk("burst_word_order", 32'(dec_log[2+k]), 32'(k + 1));

      // Clear overflow, then clear coinciding with a drop
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      tick();
      chk("ovf_cleared", 32'(overflow), 32'd0);
      for (int i = 7; i <= 11; i++) edge3(DATA_W'(i), 1'b0);
      sample_code = 12'd12;
      conv_done   = 1'b1;
      clr_ovf     = 1'b1;
      tick();
      conv_done   = 1'b0;
      clr_ovf     = 1'b0;
      chk("ovf_set_wins", 32'(overflow), 32'd1);
      wait_idle(600);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      tick();
      chk("ovf_cleared_again", 32'(overflow), 32'd0);

      // Full FIFO, IDLE pop coincides with a conv_done edge
      nf = n_frames;
      for (int i = 13; i <= 17; i++) edge3(DATA_W'(i), 1'b0);
      chk("full_before_pop", 32'(fifo_count), 32'd4);
      wait_frames(nf + 1, 200);
      tick();
      tick();
      sample_code = 12'd18;
      conv_done   = 1'b1;
      tick();
      conv_done   = 1'b0;
      chk("full_pop_push_count", 32'(fifo_count), 32'd4);
      chk("full_pop_push_no_ovf", 32'(overflow), 32'd0);
      wait_frames(nf + 6, 600);
      wait_idle(300);
      chk("full_pop_push_last", 32'(dec_log[dec_log.size()-1]), 32'd18);

      // Reset at cycle 20 of a frame
      sample_code = 12'h3C6;
      conv_done   = 1'b1;
      tick();
      conv_done   = 1'b0;
      for (int n = 0; n < 50 && cs_n !== 1'b0; n++) tick();
      chk("abort_frame_started", 32'(cs_n), 32'd0);
      repeat (5) tick();
      edge3(12'h777, 1'b0);
      repeat (12) tick();
      nf = n_frames;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_cs_n", 32'(cs_n), 32'd1);
      chk("abort_sclk", 32'(sclk), 32'd0);
      chk("abort_count", 32'(fifo_count), 32'd0);
      chk("abort_no_frame_done", 32'(frame_done), 32'd0);
      repeat (60) tick();
      chk("abort_frames_unchanged", 32'(n_frames), 32'(nf));
      sample_code = 12'h5A9;
      conv_done   = 1'b1;
      tick();
      conv_done   = 1'b0;
      wait_frames(nf + 1, 200);
      chk("after_abort_word", 32'(dec_log[dec_log.size()-1]), 32'h05A9);
      chk("after_abort_low", 32'(last_low), 32'd48);
      wait_idle(200);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) conv_done = ~conv_done;
         sample_code = DATA_W'($urandom);
         clr_ovf     = ($urandom_range(0, 59) == 0);
         reset       = ($urandom_range(0, 999) == 0);
         tick();
      end
      conv_done = 1'b0;
      clr_ovf   = 1'b0;
      reset     = 1'b0;
      wait_idle(1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
